// File: rtl/conv_seq_pkg.sv
// Shared register map, CTRL/STATUS bit positions, mode and sequencer-state types
// for the systolic-array control block.
package conv_seq_pkg;
   localparam int REG_CTRL      = 'h00;
   localparam int REG_STATUS    = 'h04;
   localparam int REG_OUT_CH    = 'h08;
   localparam int REG_SRC_BEATS = 'h0C;
   localparam int REG_DST_BEATS = 'h10;
   localparam int REG_SAMPLES   = 'h14;
   localparam int REG_CYCLES    = 'h18;

   localparam int CTRL_START  = 2;
   localparam int CTRL_LAST   = 3;
   localparam int CTRL_IRQ_EN = 4;
   localparam int STAT_BUSY   = 0;
   localparam int STAT_DONE   = 1;
   localparam int STAT_ERR    = 2;

   typedef enum logic [1:0] {MODE_IDLE = 2'd0, MODE_MATW = 2'd1, MODE_RUN = 2'd2} mode_e;
   typedef enum logic [2:0] {S_IDLE, S_WLOAD, S_INPUT, S_COMPUTE, S_OUTPUT, S_DONE} state_e;

   function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  strb);
      logic [31:0] r;
      for (int i = 0; i < 4; i++)
         r[8*i +: 8] = strb[i] ? new_val[8*i +: 8] : old_val[8*i +: 8];
      return r;
   endfunction
endpackage

// File: rtl/axil_slave_if.sv
// AXI-Lite slave handshake: one transaction at a time, emits a single-cycle
// register write strobe (aligned with BVALID rising) and a registered read path.
module axil_slave_if #(
   parameter int ADDR_W = 12
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] s_axi_awaddr,
   input  logic              s_axi_awvalid,
   output logic              s_axi_awready,
   input  logic [31:0]       s_axi_wdata,
   input  logic [3:0]        s_axi_wstrb,
   input  logic              s_axi_wvalid,
   output logic              s_axi_wready,
   output logic [1:0]        s_axi_bresp,
   output logic              s_axi_bvalid,
   input  logic              s_axi_bready,
   input  logic [ADDR_W-1:0] s_axi_araddr,
   input  logic              s_axi_arvalid,
   output logic              s_axi_arready,
   output logic [31:0]       s_axi_rdata,
   output logic [1:0]        s_axi_rresp,
   output logic              s_axi_rvalid,
   input  logic              s_axi_rready,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [31:0]       wr_data,
   output logic [3:0]        wr_strb,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [31:0]       rd_data
);
   logic aw_hold, w_hold, rd_pend, rd_busy;

   assign rd_busy       = rd_pend | s_axi_rvalid;
   assign s_axi_awready = !aw_hold && !s_axi_bvalid && !rd_busy;
   assign s_axi_wready  = !w_hold && !s_axi_bvalid && !rd_busy;
   // A read is only taken when no write is pending or being offered, so writes win ties.
   assign s_axi_arready = !rd_busy && !aw_hold && !w_hold && !s_axi_bvalid &&
                          !s_axi_awvalid && !s_axi_wvalid;
   assign s_axi_bresp   = 2'b00;
   assign s_axi_rresp   = 2'b00;

   always_ff @(posedge clk) begin
      if (reset) begin
         aw_hold      <= 1'b0;
         w_hold       <= 1'b0;
         s_axi_bvalid <= 1'b0;
         wr_en        <= 1'b0;
         rd_pend      <= 1'b0;
         s_axi_rvalid <= 1'b0;
      end else begin
         wr_en   <= 1'b0;
         rd_pend <= s_axi_arvalid && s_axi_arready;
         if (s_axi_awvalid && s_axi_awready) aw_hold <= 1'b1;
         if (s_axi_wvalid && s_axi_wready) w_hold <= 1'b1;
         if (aw_hold && w_hold) begin
            aw_hold      <= 1'b0;
            w_hold       <= 1'b0;
            s_axi_bvalid <= 1'b1;
            wr_en        <= 1'b1;
         end
         if (s_axi_bvalid && s_axi_bready) s_axi_bvalid <= 1'b0;
         if (rd_pend) s_axi_rvalid <= 1'b1;
         else if (s_axi_rvalid && s_axi_rready) s_axi_rvalid <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (s_axi_awvalid && s_axi_awready) wr_addr <= s_axi_awaddr;
      if (s_axi_wvalid && s_axi_wready) begin
         wr_data <= s_axi_wdata;
         wr_strb <= s_axi_wstrb;
      end
      if (s_axi_arvalid && s_axi_arready) rd_addr <= s_axi_araddr;
      if (rd_pend) s_axi_rdata <= rd_data;
   end
endmodule

// File: rtl/conv_seq_ctrl.sv
// Register file plus stream sequencer for the systolic MAC array.
// Optional busy-cycle counter at 0x18 when CONV_SEQ_PERF_EN is defined.
module conv_seq_ctrl
   import conv_seq_pkg::*;
#(
   parameter int NCH    = 32,
   parameter int CNT_W  = 12,
   parameter int ADDR_W = 12
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] s_axi_awaddr,
   input  logic              s_axi_awvalid,
   output logic              s_axi_awready,
   input  logic [31:0]       s_axi_wdata,
   input  logic [3:0]        s_axi_wstrb,
   input  logic              s_axi_wvalid,
   output logic              s_axi_wready,
   output logic [1:0]        s_axi_bresp,
   output logic              s_axi_bvalid,
   input  logic              s_axi_bready,
   input  logic [ADDR_W-1:0] s_axi_araddr,
   input  logic              s_axi_arvalid,
   output logic              s_axi_arready,
   output logic [31:0]       s_axi_rdata,
   output logic [1:0]        s_axi_rresp,
   output logic              s_axi_rvalid,
   input  logic              s_axi_rready,
   input  logic              s_axis_tvalid,
   output logic              s_axis_tready,
   input  logic              s_axis_tlast,
   output logic              m_axis_tvalid,
   input  logic              m_axis_tready,
   output logic              m_axis_tlast,
   output logic              src_v,
   output logic [CNT_W-1:0]  src_a,
   output logic [NCH-1:0]    prm_v,
   output logic [CNT_W-1:0]  prm_a,
   output logic              ex_start,
   input  logic              ex_done,
   output logic              dst_v,
   output logic [CNT_W-1:0]  dst_a,
   output logic              irq
);
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr, rd_addr;
   logic [31:0]       wr_data, rd_data, ctrl_rd, ctrl_new, w1c;
   logic [3:0]        wr_strb;

   axil_slave_if #(.ADDR_W(ADDR_W)) u_axil (
      .clk(clk), .reset(reset),
      .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
      .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
      .s_axi_wready(s_axi_wready), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
      .s_axi_bready(s_axi_bready), .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid),
      .s_axi_arready(s_axi_arready), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
      .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_strb(wr_strb),
      .rd_addr(rd_addr), .rd_data(rd_data)
   );

   mode_e            mode;
   state_e           state, nxt;
   logic             last, irq_en, done, err, start_q, ex_start_q;
   logic             busy, abort, wr_ctrl, wr_stat, err_set, fin_src, fin_dst, fin_smp;
   logic [CNT_W-1:0] out_ch, src_beats, dst_beats, samples, beat, ch, smp, last_ch;

   assign busy     = (state != S_IDLE);
   assign wr_ctrl  = wr_en && (wr_addr == ADDR_W'(REG_CTRL));
   assign wr_stat  = wr_en && (wr_addr == ADDR_W'(REG_STATUS));
   assign ctrl_rd  = {27'd0, irq_en, last, 1'b0, mode};
   assign ctrl_new = byte_merge(ctrl_rd, wr_data, wr_strb);
   assign w1c      = byte_merge(32'd0, wr_data, wr_strb);
   assign abort    = wr_ctrl && busy && (ctrl_new[1:0] == 2'd0);
   assign fin_src  = (beat == src_beats);
   assign fin_dst  = (beat == dst_beats);
   assign fin_smp  = (smp == samples);
   assign last_ch  = (32'(out_ch) >= NCH) ? CNT_W'(NCH - 1) : out_ch;
   // tlast must mark exactly the final beat of each input packet.
   assign err_set  = (state == S_WLOAD || state == S_INPUT) && s_axis_tvalid &&
                     (s_axis_tlast != fin_src);
   assign ex_start = ex_start_q;
   assign irq      = irq_en & (done | err);

   always_ff @(posedge clk) begin
      if (reset) begin
         mode <= MODE_IDLE; last <= 1'b0; irq_en <= 1'b0; start_q <= 1'b0;
         done <= 1'b0; err <= 1'b0;
         out_ch <= '0; src_beats <= '0; dst_beats <= '0; samples <= '0;
      end else begin
         start_q <= wr_ctrl && ctrl_new[CTRL_START] && !busy;
         if (wr_ctrl) begin
            mode   <= mode_e'(ctrl_new[1:0]);
            last   <= ctrl_new[CTRL_LAST];
            irq_en <= ctrl_new[CTRL_IRQ_EN];
         end
         if (wr_en && !busy) begin
            if (wr_addr == ADDR_W'(REG_OUT_CH))
               out_ch <= CNT_W'(byte_merge(32'(out_ch), wr_data, wr_strb));
            if (wr_addr == ADDR_W'(REG_SRC_BEATS))
               src_beats <= CNT_W'(byte_merge(32'(src_beats), wr_data, wr_strb));
            if (wr_addr == ADDR_W'(REG_DST_BEATS))
               dst_beats <= CNT_W'(byte_merge(32'(dst_beats), wr_data, wr_strb));
            if (wr_addr == ADDR_W'(REG_SAMPLES))
               samples <= CNT_W'(byte_merge(32'(samples), wr_data, wr_strb));
         end
         done <= (done && !(wr_stat && w1c[STAT_DONE])) || (state == S_DONE);
         err  <= (err && !(wr_stat && w1c[STAT_ERR])) || err_set;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) state <= S_IDLE;
      else       state <= nxt;
   end

   always_comb begin
      nxt           = state;
      s_axis_tready = 1'b0;
      src_v         = 1'b0;
      src_a         = '0;
      prm_v         = '0;
      prm_a         = '0;
      m_axis_tvalid = 1'b0;
      m_axis_tlast  = 1'b0;
      dst_v         = 1'b0;
      dst_a         = '0;
      case (state)
         S_IDLE: begin
            if (start_q && mode == MODE_MATW) nxt = S_WLOAD;
            else if (start_q && mode == MODE_RUN) nxt = S_INPUT;
         end
         S_WLOAD: begin
            s_axis_tready = 1'b1;
            prm_a         = beat;
            if (s_axis_tvalid) prm_v = NCH'(1) << ch;
            if (s_axis_tvalid && fin_src && ch == last_ch) nxt = S_DONE;
         end
         S_INPUT: begin
            s_axis_tready = 1'b1;
            src_v         = s_axis_tvalid;
            src_a         = beat;
            if (s_axis_tvalid && fin_src) nxt = S_COMPUTE;
         end
         S_COMPUTE: if (ex_done) nxt = S_OUTPUT;
         S_OUTPUT: begin
            m_axis_tvalid = 1'b1;
            dst_a         = beat;
            dst_v         = m_axis_tready;
            m_axis_tlast  = fin_dst && (!last || fin_smp);
            if (m_axis_tready && fin_dst) nxt = fin_smp ? S_DONE : S_INPUT;
         end
         S_DONE:  nxt = S_IDLE;
         default: nxt = S_IDLE;
      endcase
      if (abort) nxt = S_IDLE;
   end

   // Beat/channel/sample counters advance on the accepting edge.
   always_ff @(posedge clk) begin
      if (reset || abort) begin
         beat <= '0; ch <= '0; smp <= '0; ex_start_q <= 1'b0;
      end else begin
         ex_start_q <= (state == S_INPUT) && (nxt == S_COMPUTE);
         case (state)
            S_WLOAD: if (s_axis_tvalid) begin
               if (fin_src) begin
                  beat <= '0;
                  ch   <= (ch == last_ch) ? '0 : ch + 1'b1;
               end else beat <= beat + 1'b1;
            end
            S_INPUT: if (s_axis_tvalid) beat <= fin_src ? '0 : beat + 1'b1;
            S_OUTPUT: if (m_axis_tready) begin
               if (fin_dst) begin
                  beat <= '0;
                  smp  <= fin_smp ? '0 : smp + 1'b1;
               end else beat <= beat + 1'b1;
            end
            default: ;
         endcase
      end
   end

`ifdef CONV_SEQ_PERF_EN
   logic [31:0] cycles;
   always_ff @(posedge clk) begin
      if (reset || start_q) cycles <= '0;
      else if (busy && cycles != '1) cycles <= cycles + 1'b1;
   end
`endif

   always_comb begin
      rd_data = '0;
      case (rd_addr)
         ADDR_W'(REG_CTRL):      rd_data = ctrl_rd;
         ADDR_W'(REG_STATUS):    rd_data = {29'd0, err, done, busy};
         ADDR_W'(REG_OUT_CH):    rd_data = 32'(out_ch);
         ADDR_W'(REG_SRC_BEATS): rd_data = 32'(src_beats);
         ADDR_W'(REG_DST_BEATS): rd_data = 32'(dst_beats);
         ADDR_W'(REG_SAMPLES):   rd_data = 32'(samples);
`ifdef CONV_SEQ_PERF_EN
         ADDR_W'(REG_CYCLES):    rd_data = cycles;
`endif
         default:                rd_data = '0;
      endcase
   end
endmodule

// File: tb/tb_conv_seq_ctrl.sv
// Scoreboard bench for conv_seq_ctrl: expectations are queued as stimulus is
// issued and a negedge monitor compares register reads and stream strobes.
module tb_conv_seq_ctrl;
   logic        clk = 0, reset = 1;
   logic [11:0] s_axi_awaddr = '0, s_axi_araddr = '0;
   logic        s_axi_awvalid = 0, s_axi_awready, s_axi_wvalid = 0, s_axi_wready;
   logic [31:0] s_axi_wdata = '0, s_axi_rdata;
   logic [3:0]  s_axi_wstrb = '0;
   logic [1:0]  s_axi_bresp, s_axi_rresp;
   logic        s_axi_bvalid, s_axi_bready = 1, s_axi_arvalid = 0, s_axi_arready;
   logic        s_axi_rvalid, s_axi_rready = 1;
   logic        s_axis_tvalid = 0, s_axis_tready, s_axis_tlast = 0;
   logic        m_axis_tvalid, m_axis_tready = 0, m_axis_tlast;
   logic        src_v, dst_v, ex_start, ex_done = 0, irq;
   logic [11:0] src_a, prm_a, dst_a;
   logic [31:0] prm_v;

   int total = 0, bad = 0, exs_cnt = 0;
   logic [31:0] rd_exp_q[$];
   string       rd_name_q[$];
   logic [46:0] ev_q[$];
   logic [31:0] mon_e;
   string       mon_n;

   conv_seq_ctrl #(.NCH(32), .CNT_W(12), .ADDR_W(12)) dut (
      .clk(clk), .reset(reset),
      .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
      .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
      .s_axi_wready(s_axi_wready), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
      .s_axi_bready(s_axi_bready), .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid),
      .s_axi_arready(s_axi_arready), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
      .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
      .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
      .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
      .src_v(src_v), .src_a(src_a), .prm_v(prm_v), .prm_a(prm_a),
      .ex_start(ex_start), .ex_done(ex_done), .dst_v(dst_v), .dst_a(dst_a), .irq(irq)
   );

   always #5 clk = ~clk;

   function void chk(string nm, logic [63:0] act, logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endfunction

   function void to_fail(string nm);
      total++;
      bad++;
      $display("FAIL %s actual=timeout required=event", nm);
   endfunction

   // kind: 0 weight strobe, 1 input strobe, 2 output strobe
   function void exp_ev(logic [1:0] k, logic [31:0] v, logic [11:0] a, logic l);
      ev_q.push_back({k, v, a, l});
   endfunction

   function void ev_chk(logic [1:0] k, logic [31:0] v, logic [11:0] a, logic l);
      logic [46:0] got;
      got = {k, v, a, l};
      if (ev_q.size() == 0) chk("strobe_unexpected", 64'(got), 64'(0));
      else chk("strobe", 64'(got), 64'(ev_q.pop_front()));
   endfunction

   always @(negedge clk) begin
      if (prm_v != '0) ev_chk(2'd0, prm_v, prm_a, 1'b0);
      if (src_v) ev_chk(2'd1, 32'd0, src_a, 1'b0);
      if (dst_v) ev_chk(2'd2, 32'd0, dst_a, m_axis_tlast);
      if (ex_start) exs_cnt++;
      if (s_axi_rvalid && s_axi_rready) begin
         if (rd_exp_q.size() == 0) chk("rd_unexpected", 64'(s_axi_rdata), 64'(0));
         else begin
            mon_e = rd_exp_q.pop_front();
            mon_n = rd_name_q.pop_front();
            chk(mon_n, 64'(s_axi_rdata), 64'(mon_e));
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic axi_write(input logic [11:0] a, input logic [31:0] d);
      int t;
      s_axi_awaddr = a; s_axi_awvalid = 1; s_axi_wdata = d; s_axi_wstrb = 4'hf; s_axi_wvalid = 1;
      t = 0;
      @(negedge clk);
      while (!(s_axi_awready && s_axi_wready) && t < 50) begin @(negedge clk); t++; end
      @(posedge clk); #1;
      s_axi_awvalid = 0; s_axi_wvalid = 0;
      if (t >= 50) to_fail("aw_w_accept");
      t = 0;
      @(negedge clk);
      while (!s_axi_bvalid && t < 50) begin @(negedge clk); t++; end
      @(posedge clk); #1;
      if (t >= 50) to_fail("bvalid");
   endtask

   task automatic axi_read(input logic [11:0] a, input logic [31:0] exp, input string nm);
      int t;
      rd_exp_q.push_back(exp);
      rd_name_q.push_back(nm);
      s_axi_araddr = a; s_axi_arvalid = 1;
      t = 0;
      @(negedge clk);
      while (!s_axi_arready && t < 50) begin @(negedge clk); t++; end
      @(posedge clk); #1;
      s_axi_arvalid = 0;
      if (t >= 50) to_fail("ar_accept");
      t = 0;
      @(negedge clk);
      while (!s_axi_rvalid && t < 50) begin @(negedge clk); t++; end
      @(posedge clk); #1;
      if (t >= 50) to_fail("rvalid");
   endtask

   task automatic send(input int n, input logic [31:0] lmask);
      int t;
      for (int i = 0; i < n; i++) begin
         s_axis_tvalid = 1;
         s_axis_tlast  = lmask[i];
         t = 0;
         @(negedge clk);
         while (!s_axis_tready && t < 100) begin @(negedge clk); t++; end
         @(posedge clk); #1;
         if (t >= 100) to_fail("tready");
      end
      s_axis_tvalid = 0;
      s_axis_tlast  = 0;
   endtask

   task automatic wait_ex(input int target);
      int t;
      t = 0;
      while (exs_cnt < target && t < 100) begin @(posedge clk); t++; end
      #1;
      if (t >= 100) to_fail("ex_start");
      repeat (5) @(posedge clk);
      #1 ex_done = 1;
      @(posedge clk);
      #1 ex_done = 0;
   endtask

   task automatic drain(input int nb, input bit tog);
      int got, t;
      bit r;
      got = 0; t = 0; r = !tog;
      while (got < nb && t < 200) begin
         m_axis_tready = r;
         @(negedge clk);
         if (m_axis_tvalid && m_axis_tready) got++;
         @(posedge clk); #1;
         if (tog) r = !r;
         t++;
      end
      m_axis_tready = 0;
      if (got < nb) to_fail("drain");
   endtask

   task automatic cfg(input int och, input int src, input int dst, input int smp);
      axi_write(12'h08, 32'(och));
      axi_write(12'h0C, 32'(src));
      axi_write(12'h10, 32'(dst));
      axi_write(12'h14, 32'(smp));
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1 reset = 0;

      // reset state
      chk("rst_irq", 64'(irq), 64'(0));
      chk("rst_tready", 64'(s_axis_tready), 64'(0));
      chk("rst_awready", 64'(s_axi_awready), 64'(1));
      for (int a = 0; a <= 'h14; a += 4) axi_read(12'(a), 32'h0, "rst_reg");
      axi_read(12'h1C, 32'h0, "unmapped");

      // weight load: 2 channels x 4 beats
      cfg(1, 3, 0, 0);
      for (int c = 0; c < 2; c++)
         for (int b = 0; b < 4; b++) exp_ev(2'd0, 32'd1 << c, 12'(b), 1'b0);
      axi_write(12'h00, 32'h5);
      send(8, 32'h88);
      idle(3);
      axi_read(12'h04, 32'h2, "matw_status");
      axi_write(12'h04, 32'h2);
      axi_read(12'h04, 32'h0, "done_w1c");
      chk("matw_events_left", 64'(ev_q.size()), 64'(0));

      // OUT_CH beyond NCH clamps to 32 channels
      cfg(40, 0, 0, 0);
      for (int c = 0; c < 32; c++) exp_ev(2'd0, 32'd1 << c, 12'd0, 1'b0);
      axi_write(12'h00, 32'h5);
      send(32, 32'hFFFF_FFFF);
      idle(3);
      axi_read(12'h08, 32'd40, "out_ch_raw");
      axi_read(12'h04, 32'h2, "clamp_status");
      axi_write(12'h04, 32'h2);
      chk("clamp_events_left", 64'(ev_q.size()), 64'(0));

      // two-sample run, last=1
      cfg(0, 3, 1, 1);
      for (int s = 0; s < 2; s++) begin
         for (int b = 0; b < 4; b++) exp_ev(2'd1, 32'd0, 12'(b), 1'b0);
         exp_ev(2'd2, 32'd0, 12'd0, 1'b0);
         exp_ev(2'd2, 32'd0, 12'd1, s == 1);
      end
      axi_write(12'h00, 32'hE);
      send(4, 32'h8);
      wait_ex(1);
      drain(2, 0);
      send(4, 32'h8);
      wait_ex(2);
      drain(2, 0);
      idle(3);
      axi_read(12'h04, 32'h2, "run_status");
      chk("run_ex_starts", 64'(exs_cnt), 64'(2));
      chk("run_events_left", 64'(ev_q.size()), 64'(0));
      axi_write(12'h04, 32'h2);

      // output back-pressure toggling every cycle
      cfg(0, 0, 3, 0);
      exp_ev(2'd1, 32'd0, 12'd0, 1'b0);
      for (int b = 0; b < 4; b++) exp_ev(2'd2, 32'd0, 12'(b), b == 3);
      axi_write(12'h00, 32'hE);
      send(1, 32'h1);
      wait_ex(3);
      drain(4, 1);
      idle(3);
      axi_read(12'h04, 32'h2, "tog_status");
      chk("tog_events_left", 64'(ev_q.size()), 64'(0));
      axi_write(12'h04, 32'h2);

      // misplaced tlast -> err, irq, W1C; busy config write ignored
      cfg(0, 3, 0, 0);
      for (int b = 0; b < 4; b++) exp_ev(2'd1, 32'd0, 12'(b), 1'b0);
      exp_ev(2'd2, 32'd0, 12'd0, 1'b1);
      axi_write(12'h00, 32'h16);
      send(4, 32'h2);
      axi_read(12'h04, 32'h5, "err_status_busy");
      chk("err_irq", 64'(irq), 64'(1));
      axi_write(12'h0C, 32'h7);
      axi_read(12'h0C, 32'h3, "busy_cfg_ignored");
      axi_write(12'h04, 32'h4);
      axi_read(12'h04, 32'h1, "err_w1c");
      chk("err_irq_clr", 64'(irq), 64'(0));
      wait_ex(4);
      drain(1, 0);
      idle(3);
      axi_read(12'h04, 32'h2, "err_run_done");
      chk("done_irq", 64'(irq), 64'(1));
      axi_write(12'h04, 32'h2);
      chk("done_irq_clr", 64'(irq), 64'(0));

      // abort mid-input, then a clean run
      cfg(0, 3, 0, 0);
      exp_ev(2'd1, 32'd0, 12'd0, 1'b0);
      exp_ev(2'd1, 32'd0, 12'd1, 1'b0);
      axi_write(12'h00, 32'h6);
      send(2, 32'h0);
      axi_write(12'h00, 32'h0);
      chk("abort_tready", 64'(s_axis_tready), 64'(0));
      axi_read(12'h04, 32'h0, "abort_status");
      cfg(0, 1, 0, 0);
      exp_ev(2'd1, 32'd0, 12'd0, 1'b0);
      exp_ev(2'd1, 32'd0, 12'd1, 1'b0);
      exp_ev(2'd2, 32'd0, 12'd0, 1'b1);
      axi_write(12'h00, 32'hE);
      send(2, 32'h2);
      wait_ex(5);
      drain(1, 0);
      idle(3);
      axi_read(12'h04, 32'h2, "post_abort_status");
      chk("post_abort_ex_starts", 64'(exs_cnt), 64'(5));
      chk("post_abort_events_left", 64'(ev_q.size()), 64'(0));
      chk("rd_queue_left", 64'(rd_exp_q.size()), 64'(0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
